// File: rtl/rx_pkg.sv
// Shared defaults and state encodings for the RX symbol ping-pong buffer.
// Bank states track ownership of each buffer half between writer and reader.
package rx_pkg;

  localparam int DEF_DW        = 16;
  localparam int DEF_AW        = 7;
  localparam int DEF_FRAME_LEN = 128;
  localparam int DEF_CW        = 8;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    READING
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHOW
  } rd_state_t;

endpackage

// File: rtl/rx_sym_bank_ram.sv
// Simple dual-port symbol RAM, one {re,im} word per address, registered read.
// Ports: clk; we_re/we_im lane enables, waddr, wdata; rd_en, raddr, q.
module rx_sym_bank_ram
  import rx_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW + 1
) (
  input  logic            clk,
  input  logic            we_re,
  input  logic            we_im,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            rd_en,
  input  logic [AW-1:0]   raddr,
  output logic [2*DW-1:0] q
);

  logic [2*DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_re) mem[waddr][2*DW-1:DW] <= wdata;
    if (we_im) mem[waddr][DW-1:0] <= wdata;
    if (rd_en) q <= mem[raddr];
  end

endmodule

// File: rtl/rx_sym_pingpong.sv
// Two-bank symbol capture buffer; good frames stream out as {re,im} beats.
// Ports: clk, rst, frame writer inputs, valid/ready output stream, drop stats.
module rx_sym_pingpong
  import rx_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frameen,
  input  logic [1:0]    err,
  input  logic          symouten_re,
  input  logic          symouten_im,
  input  logic [DW-1:0] symout,
  input  logic [AW-1:0] symout_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last,
  output logic [CW-1:0] drop_cnt,
  output logic          overflow
);

  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  logic            fen_q;
  logic            start;
  logic            stop;
  bank_state_t     bs [2];
  logic            wbank;
  logic            rbank;
  logic            dropped;
  rd_state_t       st;
  rd_state_t       st_nx;
  logic [AW-1:0]   k;
  logic            hs;
  logic            rel;
  logic            grab;
  logic            start_ok;
  logic            filling;
  logic            in_rng;
  logic            wr_ok;
  logic            rd_en;
  logic [2*DW-1:0] q;
  logic [CW-1:0]   drop_inc;

  // Not reset: a frame already in flight when rst drops produces no
  // start edge, so it is ignored until its end instead of half-captured.
  always_ff @(posedge clk) fen_q <= frameen;

  assign start    = frameen & ~fen_q;
  assign stop     = ~frameen & fen_q;
  assign hs       = out_valid & out_ready;
  assign rel      = hs & (k == LAST);
  assign grab     = (st == IDLE) & (bs[rbank] == FULL);
  // A bank released by the reader this cycle counts as free.
  assign start_ok = (bs[wbank] == EMPTY) |
                    (rel & (rbank == wbank));
  assign filling  = (bs[wbank] == FILLING);
  assign in_rng   = int'(symout_addr) < FRAME_LEN;
  assign wr_ok    = frameen & in_rng &
                    (start ? start_ok : filling);
  assign drop_inc = (&drop_cnt) ? drop_cnt
                                : drop_cnt + 1'b1;

  always_comb begin
    st_nx = st;
    rd_en = 1'b0;
    unique case (st)
      IDLE:  if (grab) st_nx = FETCH;
      FETCH: begin
        rd_en = 1'b1;
        st_nx = SHOW;
      end
      SHOW:  if (hs) st_nx = rel ? IDLE : FETCH;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      k        <= '0;
      rbank    <= 1'b0;
      wbank    <= 1'b0;
      dropped  <= 1'b0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      bs[0]    <= EMPTY;
      bs[1]    <= EMPTY;
    end else begin
      st <= st_nx;
      if (grab) begin
        bs[rbank] <= READING;
        k         <= '0;
      end
      if (hs) k <= k + 1'b1;
      if (rel) begin
        bs[rbank] <= EMPTY;
        rbank     <= ~rbank;
      end
      // Writer updates come last so a same-cycle release is seen first.
      if (start) begin
        if (start_ok) bs[wbank] <= FILLING;
        else          dropped   <= 1'b1;
      end
      if (stop) begin
        dropped <= 1'b0;
        if (dropped) begin
          drop_cnt <= drop_inc;
          overflow <= 1'b1;
        end else if (err != 2'b00) begin
          if (filling) bs[wbank] <= EMPTY;
          drop_cnt <= drop_inc;
        end else if (filling) begin
          bs[wbank] <= FULL;
          wbank     <= ~wbank;
        end
      end
    end
  end

  // Depth is 2**(AW+1) so {bank,addr} addresses directly.
  rx_sym_bank_ram #(
    .DW(DW),
    .AW(AW + 1)
  ) u_ram (
    .clk   (clk),
    .we_re (wr_ok & symouten_re),
    .we_im (wr_ok & symouten_im),
    .waddr ({wbank, symout_addr}),
    .wdata (symout),
    .rd_en (rd_en),
    .raddr ({rbank, k}),
    .q     (q)
  );

  assign out_valid = (st == SHOW);
  assign out_re    = out_valid ? q[2*DW-1:DW] : '0;
  assign out_im    = out_valid ? q[DW-1:0] : '0;
  assign out_last  = out_valid & (k == LAST);

endmodule

// File: tb/tb_rx_sym_pingpong.sv
// Directed bench for rx_sym_pingpong: capture, drop, overflow, backpressure,
// short-frame range limit and reset-abandon behaviour.
module tb_rx_sym_pingpong;

  logic        clk = 1'b0;
  logic        rst;
  logic        frameen;
  logic [1:0]  err;
  logic        symouten_re;
  logic        symouten_im;
  logic [15:0] symout;
  logic [6:0]  symout_addr;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic        out_last;
  logic [7:0]  drop_cnt;
  logic        overflow;
  logic        out_ready2;
  logic        out_valid2;
  logic [15:0] out_re2;
  logic [15:0] out_im2;
  logic        out_last2;
  logic [7:0]  drop_cnt2;
  logic        overflow2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_sym_pingpong dut (
    .clk(clk), .rst(rst), .frameen(frameen), .err(err),
    .symouten_re(symouten_re), .symouten_im(symouten_im),
    .symout(symout), .symout_addr(symout_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  rx_sym_pingpong #(.FRAME_LEN(100)) dut2 (
    .clk(clk), .rst(rst), .frameen(frameen), .err(err),
    .symouten_re(symouten_re), .symouten_im(symouten_im),
    .symout(symout), .symout_addr(symout_addr),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_re(out_re2), .out_im(out_im2), .out_last(out_last2),
    .drop_cnt(drop_cnt2), .overflow(overflow2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Writes re[i]=rb+i, im[i]=ib+i for i<n, then ends the frame with e.
  // Returns just after the frame-end edge.
  task automatic wr_frame(input int n, input logic [15:0] rb,
                          input logic [15:0] ib, input logic [1:0] e);
    frameen = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      symout_addr = 7'(i);
      symout      = rb + 16'(i);
      symouten_re = 1'b1;
      symouten_im = 1'b0;
      step();
      symout      = ib + 16'(i);
      symouten_re = 1'b0;
      symouten_im = 1'b1;
      step();
    end
    symouten_im = 1'b0;
    frameen     = 1'b0;
    err         = e;
    step();
    err = 2'b00;
  endtask

  // Reads beats b0..b0+n-1 of a flen-beat frame from dut.
  task automatic rd_frame(input int b0, input int n, input int flen,
                          input logic [15:0] rb, input logic [15:0] ib,
                          input bit rnd);
    int w;
    int hold;
    for (int b = b0; b < b0 + n; b++) begin
      w = 0;
      while (!out_valid && w < 20) begin
        step();
        w++;
      end
      if (!out_valid) begin
        chk("rd_timeout", 32'(out_valid), 32'd1);
        return;
      end
      if (rnd) begin
        out_ready = 1'b0;
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
          step();
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_re", 32'(out_re), 32'(rb + 16'(b)));
        end
      end
      chk("re", 32'(out_re), 32'(rb + 16'(b)));
      chk("im", 32'(out_im), 32'(ib + 16'(b)));
      chk("last", 32'(out_last), 32'(b == flen - 1));
      out_ready = 1'b1;
      step();
      if (rnd) out_ready = 1'b0;
    end
  endtask

  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 32'(out_valid), 32'd0);
      step();
    end
  endtask

  int nb;

  initial begin
    rst         = 1'b1;
    frameen     = 1'b0;
    err         = 2'b00;
    symouten_re = 1'b0;
    symouten_im = 1'b0;
    symout      = '0;
    symout_addr = '0;
    out_ready   = 1'b0;
    out_ready2  = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_re", 32'(out_re), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();

    // Good frame, latency and full streaming.
    out_ready = 1'b1;
    wr_frame(128, 16'h0000, 16'h8000, 2'b00);
    chk("lat_e0", 32'(out_valid), 32'd0);
    step();
    chk("lat_e1", 32'(out_valid), 32'd0);
    step();
    chk("lat_e2", 32'(out_valid), 32'd1);
    rd_frame(0, 128, 128, 16'h0000, 16'h8000, 1'b0);
    idle_chk("t1_after", 6);

    // Bad frame dropped, next good frame delivered.
    wr_frame(128, 16'h1111, 16'h2222, 2'b01);
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    chk("t2_ovf", 32'(overflow), 32'd0);
    idle_chk("t2_idle", 8);
    wr_frame(128, 16'h3000, 16'h4000, 2'b00);
    rd_frame(0, 128, 128, 16'h3000, 16'h4000, 1'b0);
    idle_chk("t2_after", 4);

    // Stalled consumer: two frames buffered, third dropped.
    pulse_rst();
    out_ready = 1'b0;
    wr_frame(128, 16'h0100, 16'h0200, 2'b00);
    wr_frame(128, 16'h0300, 16'h0400, 2'b00);
    wr_frame(128, 16'h0500, 16'h0600, 2'b00);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    chk("t3_hold", 32'(out_re), 32'h0100);
    rd_frame(0, 128, 128, 16'h0100, 16'h0200, 1'b0);
    rd_frame(0, 128, 128, 16'h0300, 16'h0400, 1'b0);
    idle_chk("t3_after", 8);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Random backpressure during a read.
    out_ready = 1'b0;
    wr_frame(128, 16'h7000, 16'h9000, 2'b00);
    rd_frame(0, 128, 128, 16'h7000, 16'h9000, 1'b1);
    idle_chk("t4_after", 6);

    // Reset mid-read at beat 50, then a fresh frame from k=0.
    pulse_rst();
    out_ready = 1'b1;
    wr_frame(128, 16'hA000, 16'hB000, 2'b00);
    rd_frame(0, 50, 128, 16'hA000, 16'hB000, 1'b0);
    for (int w = 0; w < 20 && !out_valid; w++) step();
    chk("t6_beat50", 32'(out_re), 32'hA000 + 32'd50);
    pulse_rst();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    idle_chk("t6_idle", 4);
    wr_frame(128, 16'hC000, 16'hD000, 2'b00);
    rd_frame(0, 128, 128, 16'hC000, 16'hD000, 1'b0);

    // Short frame instance: addresses 100..127 are ignored.
    pulse_rst();
    chk("t5_drop", 32'(drop_cnt2), 32'd0);
    chk("t5_ovf", 32'(overflow2), 32'd0);
    wr_frame(128, 16'h1000, 16'h2000, 2'b00);
    nb = 0;
    for (int c = 0; c < 400; c++) begin
      if (out_valid2) begin
        chk("t5_re", 32'(out_re2), 32'h1000 + 32'(nb));
        chk("t5_im", 32'(out_im2), 32'h2000 + 32'(nb));
        chk("t5_last", 32'(out_last2), 32'(nb == 99));
        nb++;
      end
      step();
    end
    chk("t5_beats", 32'(nb), 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
